// File: rtl/logic_unit_arbiter.sv
// Two-requester arbiter in front of a single shared bitwise logic unit.
// Round-robin between requesters on ties, one-deep registered output slot
// with valid/ready handshake; a new result can be accepted in the same
// cycle the previous one is delivered, giving one result per cycle.
module logic_unit_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid0,
    input  logic [1:0]       op0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    output logic             ready0,
    input  logic             valid1,
    input  logic [1:0]       op1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             ready1,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             out_id,
    input  logic             out_ready
);

    // Index of the requester that wins a tie on the next contended cycle.
    logic             ptr;
    logic             slot_free;
    logic             grant0;
    logic             grant1;
    logic [1:0]       sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [WIDTH-1:0] unit_res;

    // Grant decision; reset gating keeps both readies low while reset is held,
    // independent of the clock.
    always_comb begin
        slot_free = !out_valid || out_ready;
        grant0    = !reset && valid0 && slot_free && (!valid1 || (ptr == 1'b0));
        grant1    = !reset && valid1 && slot_free && (!valid0 || (ptr == 1'b1));
        ready0    = grant0;
        ready1    = grant1;
    end

    // Only the granted requester's operands reach the shared unit.
    always_comb begin
        sel_op = grant1 ? op1 : op0;
        sel_a  = grant1 ? a1  : a0;
        sel_b  = grant1 ? b1  : b0;
    end

    // The one shared bitwise logic unit.
    always_comb begin
        unit_res = '0;
        case (sel_op)
            2'b00:   unit_res = sel_a | sel_b;
            2'b01:   unit_res = sel_a & sel_b;
            2'b10:   unit_res = sel_a ^ sel_b;
            default: unit_res = ~sel_a;
        endcase
    end

    // Output slot and round-robin pointer; out/out_id hold after delivery.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out       <= '0;
            out_id    <= 1'b0;
            out_valid <= 1'b0;
            ptr       <= 1'b0;
        end else if (grant0 || grant1) begin
            out       <= unit_res;
            out_id    <= grant1;
            out_valid <= 1'b1;
            // pointer moves to the requester that was not served
            ptr       <= grant0;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Bench for logic_unit_arbiter: directed scenarios with literal expectations
// followed by randomized traffic compared each cycle against a behavioural
// model and a queue of accepted-but-undelivered results.
module tb_logic_unit_arbiter;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         valid0, valid1, out_ready;
    logic [1:0]   op0, op1;
    logic [W-1:0] a0, b0, a1, b1;
    logic         ready0, ready1, out_valid, out_id;
    logic [W-1:0] out;

    int checks = 0;
    int errors = 0;

    logic         m_ptr, m_valid, m_id;
    logic [W-1:0] m_out;
    logic [W:0]   sb_q[$];
    logic         acc0, acc1;

    logic [W-1:0] alt_exp [4];

    logic_unit_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .valid0(valid0), .op0(op0), .a0(a0), .b0(b0), .ready0(ready0),
        .valid1(valid1), .op1(op1), .a1(a1), .b1(b1), .ready1(ready1),
        .out(out), .out_valid(out_valid), .out_id(out_id), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] lu(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            2'd0:    return a | b;
            2'd1:    return a & b;
            2'd2:    return a ^ b;
            default: return ~a;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr   = 1'b0;
        m_valid = 1'b0;
        m_id    = 1'b0;
        m_out   = '0;
        sb_q.delete();
    endtask

    // Holds reset across an edge with valid requesters present, checks the
    // reset state, then releases between edges.
    task automatic do_reset();
        reset = 1'b1;
        valid0 = 1'b1; valid1 = 1'b1; out_ready = 1'b1;
        op0 = 2'd0; op1 = 2'd0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        @(posedge clk); #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out", out, 0);
        chk("rst_out_id", out_id, 0);
        chk("rst_ready0", ready0, 0);
        chk("rst_ready1", ready1, 0);
        reset = 1'b0;
        valid0 = 1'b0; valid1 = 1'b0;
        model_reset();
    endtask

    // One clock cycle: check handshake against the model, advance the model
    // across the edge, then check the registered outputs.
    task automatic step(output logic g0, output logic g1);
        logic       slot, any, w;
        logic [W:0] e;
        #1;
        slot = !m_valid || out_ready;
        any  = valid0 || valid1;
        w    = (valid0 && valid1) ? m_ptr : valid1;
        g0   = slot && any && !w;
        g1   = slot && any && w;
        chk("ready0", ready0, g0);
        chk("ready1", ready1, g1);
        if (m_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL deliver_empty actual=delivery required=none");
            end else begin
                e = sb_q.pop_front();
                chk("deliver_data", out, e[W-1:0]);
                chk("deliver_id", out_id, e[W]);
            end
        end
        if (g0 || g1) begin
            m_out   = w ? lu(op1, a1, b1) : lu(op0, a0, b0);
            m_id    = w;
            m_valid = 1'b1;
            m_ptr   = !w;
            sb_q.push_back({m_id, m_out});
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk); #1;
        chk("out_valid", out_valid, m_valid);
        chk("out", out, m_out);
        chk("out_id", out_id, m_id);
    endtask

    initial begin
        alt_exp[0] = 16'hFFFF; alt_exp[1] = 16'h5555;
        alt_exp[2] = 16'hFFFF; alt_exp[3] = 16'h5555;

        do_reset();

        // single requester 0, OR
        valid0 = 1'b1; op0 = 2'b00; a0 = 16'h00F0; b0 = 16'h0F00; out_ready = 1'b1;
        #1 chk("first_ready0", ready0, 1);
        step(acc0, acc1);
        valid0 = 1'b0;
        chk("first_out", out, 16'h0FF0);
        chk("first_id", out_id, 0);
        chk("first_valid", out_valid, 1);
        step(acc0, acc1);
        chk("drained_valid", out_valid, 0);

        // both requesters continuously -> alternation
        do_reset();
        valid0 = 1'b1; op0 = 2'b01; a0 = 16'hFFFF; b0 = 16'hFFFF;
        valid1 = 1'b1; op1 = 2'b10; a1 = 16'hAAAA; b1 = 16'hFFFF;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(acc0, acc1);
            chk("alt_out", out, alt_exp[i]);
            chk("alt_id", out_id, i % 2);
            chk("alt_valid", out_valid, 1);
        end

        // stall with both valid
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_ready0", ready0, 0);
            chk("stall_ready1", ready1, 0);
            step(acc0, acc1);
            chk("stall_out", out, 16'h5555);
            chk("stall_id", out_id, 1);
        end
        out_ready = 1'b1;
        #1 chk("unstall_ready0", ready0, 1);
        chk("unstall_ready1", ready1, 0);
        step(acc0, acc1);
        chk("unstall_out", out, 16'hFFFF);
        chk("unstall_id", out_id, 0);

        // only requester 1, NOT
        valid0 = 1'b0;
        valid1 = 1'b1; op1 = 2'b11; a1 = 16'h1234; b1 = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            #1 chk("solo1_ready1", ready1, 1);
            step(acc0, acc1);
            chk("solo1_out", out, 16'hEDCB);
            chk("solo1_id", out_id, 1);
        end

        // asynchronous reset between edges while a result is held
        valid0 = 1'b1; op0 = 2'b01; a0 = 16'hFFFF; b0 = 16'hFFFF;
        valid1 = 1'b1; op1 = 2'b10; a1 = 16'hAAAA; b1 = 16'hFFFF;
        out_ready = 1'b0;
        #1 chk("pre_async_valid", out_valid, 1);
        #1 reset = 1'b1;
        #1;
        chk("async_out_valid", out_valid, 0);
        chk("async_out", out, 0);
        chk("async_out_id", out_id, 0);
        chk("async_ready0", ready0, 0);
        chk("async_ready1", ready1, 0);
        @(posedge clk); #2;
        chk("async_hold_valid", out_valid, 0);
        reset = 1'b0;
        model_reset();
        out_ready = 1'b1;
        #1 chk("post_rst_tie_ready0", ready0, 1);
        chk("post_rst_tie_ready1", ready1, 0);
        step(acc0, acc1);
        chk("post_rst_out", out, 16'hFFFF);
        chk("post_rst_id", out_id, 0);

        // randomized traffic; requesters hold their request until accepted
        do_reset();
        acc0 = 1'b0; acc1 = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            if (!valid0 || acc0) begin
                valid0 = ($urandom_range(0, 9) < 6);
                op0 = 2'($urandom); a0 = W'($urandom); b0 = W'($urandom);
            end
            if (!valid1 || acc1) begin
                valid1 = ($urandom_range(0, 9) < 6);
                op1 = 2'($urandom); a1 = W'($urandom); b1 = W'($urandom);
            end
            out_ready = ($urandom_range(0, 9) < 7);
            step(acc0, acc1);
        end

        // drain: every accepted request must have been delivered once
        valid0 = 1'b0; valid1 = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) step(acc0, acc1);
        chk("drain_pending", sb_q.size(), 0);
        chk("drain_valid", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/logic_unit_arbiter.md
LOGIC_UNIT_ARBITER -- requirements
Module: logic_unit_arbiter

Interface
REQ-001 Parameter: WIDTH, 16, operand/result bit width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 valid0  input  1  requester 0 has an operation pending.
REQ-005 op0  input  2  requester 0 opcode: 00 OR, 01 AND, 10 XOR, 11 NOT a.
REQ-006 a0, b0  input  WIDTH each  requester 0 operands.
REQ-007 ready0  output  1  requester 0 accepted this cycle.
REQ-008 valid1, op1, a1, b1  input  1/2/WIDTH/WIDTH  requester 1, same meaning as requester 0.
REQ-009 ready1  output  1  requester 1 accepted this cycle.
REQ-010 out  output  WIDTH  registered result of the shared logic unit.
REQ-011 out_valid  output  1  out holds an undelivered result.
REQ-012 out_id  output  1  index of the requester that issued the result on out.
REQ-013 out_ready  input  1  consumer takes out this cycle when out_valid is 1.

Function
REQ-014 The block SHALL contain exactly one bitwise logic unit shared by both requesters; only the granted requester's op/a/b reach it.
REQ-015 Opcode results SHALL be per bit: 00 a|b, 01 a&b, 10 a^b, 11 ~a (b ignored).
REQ-016 slot_free SHALL equal (!out_valid || out_ready), evaluated combinationally in the same cycle.
REQ-017 grant0 SHALL equal valid0 & slot_free & (!valid1 | ptr==0); grant1 SHALL equal valid1 & slot_free & (!valid0 | ptr==1); at most one grant per cycle.
REQ-018 ready0/ready1 SHALL equal grant0/grant1 combinationally; ready may depend on valid, valid SHALL NOT be required to depend on ready.
REQ-019 A transfer occurs when valid_i & ready_i; on that edge out<=unit result, out_id<=i, out_valid<=1.
REQ-020 Latency SHALL be one cycle: accept at edge N, result visible on out from edge N onward until delivered.
REQ-021 Priority pointer ptr (1 bit) SHALL become the index of the non-granted requester after every grant; unchanged when no grant.
REQ-022 With only one requester valid, it SHALL be granted every cycle slot_free is 1, regardless of ptr.
REQ-023 When out_valid & out_ready and no grant, out_valid SHALL clear; out and out_id SHALL hold their last values.
REQ-024 Simultaneous delivery and grant in one cycle SHALL give back-to-back results with no bubble (throughput one per cycle).
REQ-025 When out_valid & !out_ready, both ready outputs SHALL be 0 and out/out_id/out_valid SHALL hold stable.
REQ-026 A requester SHALL keep valid, op and operands stable until accepted; the block SHALL not check this.
REQ-027 No result SHALL be dropped or duplicated; each accepted request produces exactly one out_valid&out_ready transfer.

Reset
REQ-028 While reset is 1: out=0, out_valid=0, out_id=0, ptr=0, ready0=0, ready1=0, independent of clk.
REQ-029 Reset asserted mid-operation SHALL discard any undelivered result immediately; no transfer completes while reset is 1.
REQ-030 First edge after reset deasserts SHALL apply REQ-017 with ptr=0 (requester 0 wins a tie).

Verification
REQ-031 After reset, valid0=1 op0=00 a0=16'h00F0 b0=16'h0F00, out_ready=1 -> ready0=1 that cycle; next cycle out=16'h0FF0, out_id=0, out_valid=1.
REQ-032 Both valid continuously, op0=01 a0=b0=16'hFFFF, op1=10 a1=16'hAAAA b1=16'hFFFF, out_ready=1 -> grants alternate 0,1,0,1; outs alternate 16'hFFFF (id 0) and 16'h5555 (id 1), one per cycle.
REQ-033 out_valid=1, out_ready=0 for 3 cycles with both requesters valid -> ready0=ready1=0, out stable; out_ready=1 -> stalled winner by ptr accepted same cycle, new result next cycle.
REQ-034 Only valid1 asserted, op1=11 a1=16'h1234, ptr=1 or 0 -> granted each cycle; out=16'hEDCB, out_id=1.
REQ-035 Reset pulsed asynchronously between edges while out_valid=1 -> out_valid, out, out_id, ready drop to 0 before next edge; after release, tie goes to requester 0.
